// File: rtl/sp_core_pkg.sv
// sp_core_pkg: shared widths and opcode/write-back encodings for sp_core.
package sp_core_pkg;
  localparam int DW   = 16;
  localparam int NREG = 16;
  typedef enum logic [3:0] {
    ALU_CLR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_MAD, ALU_INC, ALU_CID, ALU_NCR,
    ALU_EQ, ALU_NE, ALU_LT, ALU_GT
  } aluc_e;
  typedef enum logic [1:0] {S2_ALU, S2_IMM, S2_MEM, S2_ALU3} s2_e;
endpackage

// File: rtl/sp_core_alu.sv
// sp_core_alu: combinational ALU result and compare outcome; MUL/MAD need SP_CORE_MUL_EN.
module sp_core_alu
  import sp_core_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int N_CORES = 1
) (
  input  logic [3:0]    aluc_i,
  input  logic [DW-1:0] rx_i,
  input  logic [DW-1:0] ry_i,
  input  logic [DW-1:0] rz_i,
  output logic [DW-1:0] res_o,
  output logic          cmp_o,
  output logic          is_cmp_o
);
  logic [DW-1:0] mul_res, mad_res;
`ifdef SP_CORE_MUL_EN
  assign mul_res = ry_i * rz_i;
  assign mad_res = rx_i + mul_res;
`else
  assign mul_res = '0;
  assign mad_res = '0;
`endif
  always_comb begin
    res_o = '0;
    case (aluc_i)
      ALU_ADD: res_o = ry_i + rz_i;
      ALU_SUB: res_o = ry_i - rz_i;
      ALU_MUL: res_o = mul_res;
      ALU_MAD: res_o = mad_res;
      ALU_INC: res_o = rx_i + 16'd1;
      ALU_CID: res_o = DW'(CORE_ID);
      ALU_NCR: res_o = DW'(N_CORES);
      default: res_o = '0;
    endcase
  end
  assign is_cmp_o = aluc_i[3:2] == 2'b10;
  assign cmp_o = (aluc_i[1:0] == 2'd0) ? (rx_i == ry_i) :
                 (aluc_i[1:0] == 2'd1) ? (rx_i != ry_i) :
                 (aluc_i[1:0] == 2'd2) ? (rx_i <  ry_i) : (rx_i > ry_i);
endmodule

// File: rtl/sp_core.sv
// sp_core: 16x16 register file, write-back mux and predicate flag around sp_core_alu.
// Define SP_CORE_MUL_EN to build the multiplier (MUL/MAD); otherwise those ops return 0.
module sp_core
  import sp_core_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int N_CORES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    x,
  input  logic [3:0]    y,
  input  logic [3:0]    z,
  input  logic [DW-1:0] I,
  output logic          P,
  output logic [DW-1:0] data_out,
  output logic [DW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          en,
  input  logic          reg_we,
  input  logic [3:0]    aluc,
  input  logic [1:0]    s2
);
  logic [DW-1:0] rf_q [NREG];
  logic          p_q, p_d;
  logic [DW-1:0] alu_res, wb_d;
  logic          cmp, is_cmp;
  sp_core_alu #(.CORE_ID(CORE_ID), .N_CORES(N_CORES)) u_alu (
    .aluc_i(aluc), .rx_i(rf_q[x]), .ry_i(rf_q[y]), .rz_i(rf_q[z]),
    .res_o(alu_res), .cmp_o(cmp), .is_cmp_o(is_cmp)
  );
  always_comb begin
    wb_d = (s2 == S2_IMM) ? I : (s2 == S2_MEM) ? data_in : alu_res;
    p_d  = (en && is_cmp) ? cmp : p_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      p_q <= 1'b0;
    end else begin
      if (en && reg_we) rf_q[x] <= wb_d;
      p_q <= p_d;
    end
  end
  assign P        = p_q;
  assign data_out = rf_q[x];
  assign addr     = rf_q[y];
endmodule

// File: tb/tb_sp_core.sv
// tb_sp_core: randomized scoreboard bench for sp_core against an arithmetic reference model.
module tb_sp_core;
  import sp_core_pkg::*;
  localparam int CID = 100;
  localparam int NC  = 200;
  logic clk = 0, reset = 0, en = 0, reg_we = 0, P;
  logic [3:0] x = 0, y = 0, z = 0, aluc = 0;
  logic [1:0] s2 = 0;
  logic [15:0] I = 0, data_in = 0, data_out, addr;
  always #5 clk = ~clk;
  sp_core #(.CORE_ID(CID), .N_CORES(NC)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .z(z), .I(I), .P(P),
    .data_out(data_out), .addr(addr), .data_in(data_in), .en(en),
    .reg_we(reg_we), .aluc(aluc), .s2(s2)
  );
  typedef struct {string name; logic p; logic [15:0] d; logic [15:0] a;} exp_t;
  exp_t q[$];
  event chk_ev;
  int passed = 0, total = 0;
  longint m_r[16];
  logic m_p = 0;
  function automatic longint m_alu(int op, longint a, longint b, longint c);
    longint prod;
`ifdef SP_CORE_MUL_EN
    prod = b * c;
`else
    prod = -1;
`endif
    case (op)
      1: return (b + c) % 65536;
      2: return (b - c + 65536) % 65536;
      3: return prod < 0 ? 0 : prod % 65536;
      4: return prod < 0 ? 0 : (a + prod) % 65536;
      5: return (a + 1) % 65536;
      6: return CID;
      7: return NC;
      default: return 0;
    endcase
  endfunction
  function automatic logic m_cmp(int op, longint a, longint b);
    return op == 8 ? a == b : op == 9 ? a != b : op == 10 ? a < b : a > b;
  endfunction
  task automatic push_exp(string name);
    exp_t e;
    e.name = name;
    e.p = m_p;
    e.d = 16'(m_r[x]);
    e.a = 16'(m_r[y]);
    q.push_back(e);
  endtask
  task automatic step(input logic e_en, input logic we, input int op, input int src,
                      input int xi, input int yi, input int zi, input int imm, input int din,
                      input string name);
    longint wb;
    @(negedge clk);
    en = e_en; reg_we = we; aluc = 4'(op); s2 = 2'(src);
    x = 4'(xi); y = 4'(yi); z = 4'(zi); I = 16'(imm); data_in = 16'(din);
    wb = src == 1 ? longint'(imm) : src == 2 ? longint'(din) : m_alu(op, m_r[xi], m_r[yi], m_r[zi]);
    if (reset && e_en && op >= 8 && op <= 11) m_p = m_cmp(op, m_r[xi], m_r[yi]);
    if (reset && e_en && we) m_r[xi] = wb;
    push_exp(name);
  endtask
  task automatic async_reset_check(string name);
    @(negedge clk);
    reset = 0;
    foreach (m_r[i]) m_r[i] = 0;
    m_p = 0;
    push_exp(name);
    -> chk_ev;
    #2;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk, chk_ev);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        total++;
        if (P === e.p && data_out === e.d && addr === e.a) passed++;
        else $display("FAIL %s: got P=%0b data_out=%h addr=%h, expected P=%0b data_out=%h addr=%h",
                      e.name, P, data_out, addr, e.p, e.d, e.a);
      end
    end
  end
  initial begin
    foreach (m_r[i]) m_r[i] = 0;
    #3;
    push_exp("reset_state");
    -> chk_ev;
    #10;
    @(negedge clk) reset = 1;
    step(1, 1, 0, 1, 0, 0, 0, 11, 0, "imm_r0");
    step(1, 1, 0, 1, 1, 0, 0, 20, 0, "imm_r1");
    step(1, 1, ALU_ADD, 0, 2, 0, 1, 0, 0, "add");
    step(1, 1, ALU_MAD, 0, 2, 0, 1, 0, 0, "mad");
    step(1, 1, ALU_ADD, 0, 2, 0, 1, 0, 0, "add2");
    step(1, 1, ALU_MUL, 0, 2, 0, 1, 0, 0, "mul");
    step(1, 1, ALU_SUB, 0, 5, 0, 1, 0, 0, "sub_wrap");
    step(1, 1, ALU_CID, 0, 3, 0, 0, 0, 0, "core_id");
    step(1, 1, ALU_NCR, 0, 6, 0, 0, 0, 0, "n_cores");
    step(1, 1, ALU_CLR, 0, 3, 0, 0, 0, 0, "clear");
    step(1, 1, ALU_INC, 0, 3, 0, 0, 0, 0, "inc");
    step(1, 1, 0, 1, 3, 0, 0, 16'hFFFF, 0, "imm_ffff");
    step(1, 1, ALU_INC, 3, 3, 0, 0, 0, 0, "inc_wrap");
    step(1, 0, ALU_EQ, 0, 1, 1, 0, 0, 0, "eq_p1");
    step(1, 0, ALU_LT, 0, 1, 0, 0, 0, 0, "lt_p0");
    step(0, 0, ALU_EQ, 0, 1, 1, 0, 0, 0, "en0_p_hold");
    step(1, 1, ALU_GT, 0, 2, 0, 0, 0, 0, "gt_writes0");
    step(1, 1, 0, 2, 4, 0, 0, 0, 16'h1234, "load");
    step(0, 1, 0, 1, 4, 1, 0, 16'hBEEF, 0, "en0_hold");
    step(1, 0, 0, 1, 4, 2, 0, 16'hBEEF, 0, "we0_hold");
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
           $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 65535), "random");
    async_reset_check("async_reset");
    step(1, 1, 0, 1, 7, 7, 0, 16'h5555, 0, "write_in_reset");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, i, 15 - i, 0, 0, 0, "reset_scan");
    @(negedge clk) reset = 1;
    step(1, 1, 0, 1, 9, 9, 0, 16'h0A0A, 0, "first_write");
    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sp_core.md
SP_CORE -- requirements
Module: sp_core

Interface
- REQ-001: Parameter CORE_ID SHALL default to 0; it is the core's index, returned by the CORE_ID operation.
- REQ-002: Parameter N_CORES SHALL default to 1; it is the core count, returned by the N_CORES operation.
- REQ-003: clk SHALL be an input, 1 bit: the only clock; all state updates on its rising edge.
- REQ-004: reset SHALL be an input, 1 bit: asynchronous, active-low reset.
- REQ-005: x, y, z SHALL be inputs, 4 bits each: register-file indices (x = destination and first source; y, z = sources).
- REQ-006: I SHALL be an input, 16 bits: immediate operand.
- REQ-007: P SHALL be an output, 1 bit: predicate flag.
- REQ-008: data_out SHALL be an output, 16 bits: store data, equal to R[x].
- REQ-009: addr SHALL be an output, 16 bits: memory address, equal to R[y].
- REQ-010: data_in SHALL be an input, 16 bits: memory load data.
- REQ-011: en SHALL be an input, 1 bit: core enable.
- REQ-012: reg_we SHALL be an input, 1 bit: register write enable.
- REQ-013: aluc SHALL be an input, 4 bits: ALU operation select.
- REQ-014: s2 SHALL be an input, 2 bits: write-back source select.

Function
- REQ-015: The core SHALL hold a 16 x 16-bit register file R[0..15]; R[x], R[y] and R[z] SHALL be read combinationally.
- REQ-016: On a rising clk edge with en=1 and reg_we=1, R[x] SHALL be written with the write-back value; otherwise R[x] SHALL hold.
- REQ-017: The write-back value SHALL be selected by s2: 0 = ALU result, 1 = I, 2 = data_in, 3 = ALU result.
- REQ-018: The combinational ALU result SHALL depend on aluc as follows:
  - 0 CLEAR = 0
  - 1 ADD = R[y]+R[z]
  - 2 SUB = R[y]-R[z]
  - 3 MUL = R[y]*R[z]
  - 4 MAD = R[x]+R[y]*R[z]
  - 5 INC = R[x]+1
  - 6 CORE_ID
  - 7 N_CORES
  - 8..11 compare codes (EQ, NE, LT, GT), result 0
  - 12..15 result 0
- REQ-019: All arithmetic SHALL be unsigned and truncated to the low 16 bits (wrap-around, e.g. 0xFFFF+1 = 0).
- REQ-020: Compare codes SHALL evaluate R[x] op R[y], unsigned (8 EQ, 9 NE, 10 LT, 11 GT).
- REQ-021: On a rising clk edge with en=1 and aluc in 8..11, P SHALL load the compare outcome; otherwise P SHALL hold.
- REQ-022: P updates SHALL be independent of reg_we; a compare with reg_we=1 SHALL also write 0 to R[x] when s2 selects the ALU.
- REQ-023: With en=0, neither the register file nor P SHALL change; data_out and addr SHALL still track R[x] and R[y].
- REQ-024: When a register is read and written in the same cycle, the read SHALL return the old value until the edge (no bypass).
- REQ-025: Write-back latency SHALL be one clock edge; a written value SHALL be visible on read ports immediately after that edge.

Reset
- REQ-026: While reset=0, all R[i], and therefore data_out and addr, SHALL be 0x0000, and P SHALL be 0.
- REQ-027: Reset assertion SHALL take effect asynchronously and override any write in progress.
- REQ-028: After reset deasserts, the first write SHALL occur on the first qualifying rising edge.

Configuration
- REQ-029: Macro SP_CORE_MUL_EN SHALL control the multiplier.
  - Defined: MUL and MAD SHALL behave per REQ-018.
  - Undefined: no multiplier SHALL be synthesized, and aluc 3 and 4 SHALL yield 0.

Structure
- REQ-030: A shared package SHALL hold the data width (16), register count (16), aluc encodings and s2 encodings.
- REQ-031: The ALU (result and compare outcome) SHALL be one sub-module, sp_core_alu; the register file and mux SHALL be inline in sp_core.

Verification (CORE_ID=100, N_CORES=200, SP_CORE_MUL_EN defined)
- REQ-032: Immediate load: s2=1, reg_we=1; I=11 to x=0, then I=20 to x=1 -> R0=11, R1=20.
- REQ-033: Arithmetic sequence, each op s2=0 and x=2, y=0, z=1 -> ADD gives R2=31, then MAD gives R2=251, then ADD gives R2=31, then MUL gives R2=220.
- REQ-034: Register-only ops on x=3: CORE_ID -> R3=100; CLEAR -> R3=0; INC -> R3=1; R3=0xFFFF then INC -> R3=0.
- REQ-035: Predicate: EQ with x=y=1 -> P=1; then LT with R0=11, R1=20, x=1, y=0 -> P=0; en=0 during a compare -> P holds.
- REQ-036: Load/store and reset: s2=2, data_in=0x1234 -> R[x]=0x1234; data_out=R[x] and addr=R[y]; reset=0 mid-run -> all registers and P are 0 immediately, with no clock edge required.
